alarm_ring_controller: RTL and testbench

//  Sequences the alarm output of the digital clock. Consumes the alarm/time match flag, the 1 Hz

---
 rtl/alarm_pkg.sv | 35 +++
 rtl/alarm_countdown.sv | 43 ++++
 rtl/alarm_ring_controller.sv | 149 ++++++++++++++
 tb/tb_alarm_ring_controller.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// ---------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the alarm ring controller:
//   - alarm_state_t  : FSM state encodings, equal to the values on the 'state' port
//   - alarm_action_t : the single decision the controller takes in a given cycle
//   - DEF_*          : default timing constants
// ---------------------------------------------------------------------------
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_RINGING = 2'b10,
    ST_SNOOZE  = 2'b11
  } alarm_state_t;

  // One action per cycle. The inputs are prioritised into exactly one of these,
  // and the FSM and the countdown both act on the same decision.
  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_DISARM,  // arm switch off: back to IDLE from any state
    ACT_ARM,     // IDLE -> ARMED
    ACT_RING,    // new alarm event: ARMED -> RINGING
    ACT_STOP,    // stop button or ring timeout: back to ARMED
    ACT_SNOOZE,  // RINGING -> SNOOZE, consumes one snooze
    ACT_RESUME,  // snooze period over: SNOOZE -> RINGING
    ACT_TICK     // one-second tick while ringing without a timeout
  } alarm_action_t;

  localparam int DEF_RING_TIMEOUT_S = 60;
  localparam int DEF_SNOOZE_S       = 300;
  localparam int DEF_MAX_SNOOZES    = 3;
  localparam int DEF_TW             = 16;

endpackage

// File: rtl/alarm_countdown.sv
// ---------------------------------------------------------------------------
// alarm_countdown
// Loadable TW-bit seconds down-counter that is advanced by tick_seg.
//   clock, reset : board clock, synchronous active-high reset
//   tick         : one-cycle pulse once per second
//   clear        : force the count to 0 (highest priority after reset)
//   load         : load load_val (wins over tick)
//   load_val     : value to load
//   expire       : combinational, high for the cycle in which a tick arrives with count = 1
// The count saturates at 0; a tick at 0 does nothing.
// ---------------------------------------------------------------------------
module alarm_countdown #(
  parameter int TW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          tick,
  input  logic          clear,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          expire
);

  logic [TW-1:0] count;

  // Combinational so the FSM can react in the same cycle as the last tick.
  assign expire = tick && (count == TW'(1));

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - TW'(1);
    end
  end

endmodule

// File: rtl/alarm_ring_controller.sv
// ---------------------------------------------------------------------------
// alarm_ring_controller
// Arm / ring / snooze sequencer for the digital-clock alarm.
// Ports:
//   clock         in   board clock, rising edge
//   reset         in   synchronous, active-high reset
//   tick_seg      in   one-cycle pulse once per second
//   alarm_match   in   level, 1 while the current hh:mm equals the alarm hh:mm
//   alarm_arm     in   level switch, 1 = alarm enabled
//   snooze_pulse  in   one-cycle debounced button impulse
//   stop_pulse    in   one-cycle debounced button impulse
//   buzzer        out  registered buzzer drive
//   state         out  00 IDLE, 01 ARMED, 10 RINGING, 11 SNOOZE (registered)
//   snoozes_left  out  snoozes remaining for the current alarm event
// Only a rising edge of alarm_match starts an event, so a match that is
// already high when the alarm is armed, or that stays high after a stop,
// does not ring again.
// Configuration macro ALARM_BEEP_PATTERN_EN: when defined, the buzzer toggles
// on every tick while ringing (0.5 Hz beep); otherwise it is a steady 1.
// ---------------------------------------------------------------------------
module alarm_ring_controller
  import alarm_pkg::*;
#(
  parameter int RING_TIMEOUT_S = DEF_RING_TIMEOUT_S,
  parameter int SNOOZE_S       = DEF_SNOOZE_S,
  parameter int MAX_SNOOZES    = DEF_MAX_SNOOZES,
  parameter int TW             = DEF_TW
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_seg,
  input  logic       alarm_match,
  input  logic       alarm_arm,
  input  logic       snooze_pulse,
  input  logic       stop_pulse,
  output logic       buzzer,
  output logic [1:0] state,
  output logic [1:0] snoozes_left
);

  alarm_state_t  state_q;
  alarm_action_t action;
  logic          match_q;
  logic          trig;
  logic          expire;
  logic          cnt_clear;
  logic          cnt_load;
  logic [TW-1:0] cnt_val;

  assign trig  = alarm_match && !match_q;
  assign state = state_q;

  // Prioritise the inputs into one action:
  // arm=0 > stop > snooze > tick.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    action = ACT_NONE;
    if (!alarm_arm) begin
      action = ACT_DISARM;
    end else begin
      unique case (state_q)
        ST_IDLE:    action = ACT_ARM;
        ST_ARMED:   if (trig) action = ACT_RING;
        ST_RINGING: begin
          if (stop_pulse)                                action = ACT_STOP;
          else if (snooze_pulse && snoozes_left != 2'd0) action = ACT_SNOOZE;
          else if (expire)                               action = ACT_STOP;
          else if (tick_seg)                             action = ACT_TICK;
        end
        ST_SNOOZE: begin
          if (stop_pulse)  action = ACT_STOP;
          else if (expire) action = ACT_RESUME;
        end
        default: action = ACT_NONE;
      endcase
    end
  end

  // Countdown control follows the action. A plain tick just decrements.
  always_comb begin
    cnt_clear = (action == ACT_DISARM) || (action == ACT_STOP);
    cnt_load  = (action == ACT_RING) || (action == ACT_SNOOZE) || (action == ACT_RESUME);
    cnt_val   = (action == ACT_SNOOZE) ? TW'(SNOOZE_S) : TW'(RING_TIMEOUT_S);
  end

  alarm_countdown #(
    .TW(TW)
  ) u_countdown (
    .clock    (clock),
    .reset    (reset),
    .tick     (tick_seg),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .load_val (cnt_val),
    .expire   (expire)
  );

  // FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      buzzer       <= 1'b0;
      snoozes_left <= 2'd0;
      match_q      <= 1'b0;
    end else begin
      match_q <= alarm_match;
      unique case (action)
        ACT_DISARM: begin
          state_q      <= ST_IDLE;
          buzzer       <= 1'b0;
          snoozes_left <= 2'd0;
        end
        ACT_ARM: begin
          state_q <= ST_ARMED;
        end
        ACT_RING: begin
          state_q      <= ST_RINGING;
          buzzer       <= 1'b1;
          snoozes_left <= 2'(MAX_SNOOZES);
        end
        ACT_STOP: begin
          state_q      <= ST_ARMED;
          buzzer       <= 1'b0;
          snoozes_left <= 2'd0;
        end
        ACT_SNOOZE: begin
          state_q      <= ST_SNOOZE;
          buzzer       <= 1'b0;
          snoozes_left <= snoozes_left - 2'd1;
        end
        ACT_RESUME: begin
          state_q <= ST_RINGING;
          buzzer  <= 1'b1;
        end
        ACT_TICK: begin
`ifdef ALARM_BEEP_PATTERN_EN
          buzzer <= ~buzzer;
`else
          buzzer <= 1'b1;
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_ring_controller.sv
// ---------------------------------------------------------------------------
// tb_alarm_ring_controller
// Directed scenarios followed by randomized traffic. Every cycle the DUT
// outputs are compared against a behavioural model of the alarm rules.
// ---------------------------------------------------------------------------
module tb_alarm_ring_controller;

  localparam int RING = 60;
  localparam int SNZ  = 300;
  localparam int MAXS = 3;
  localparam int TW   = 16;

  // Output codes of the state port.
  localparam int S_IDLE = 0, S_ARMED = 1, S_RINGING = 2, S_SNOOZE = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick_seg = 1'b0;
  logic       alarm_match = 1'b0;
  logic       alarm_arm = 1'b0;
  logic       snooze_pulse = 1'b0;
  logic       stop_pulse = 1'b0;
  logic       buzzer;
  logic [1:0] state;
  logic [1:0] snoozes_left;

  int total = 0;
  int bad   = 0;

  bit cur_arm   = 1'b0;
  bit cur_match = 1'b0;

  // Model of the alarm behaviour.
  int m_state = S_IDLE;
  int m_left  = 0;
  int m_timer = 0;
  bit m_buz   = 1'b0;
  bit m_prev_match = 1'b0;

  alarm_ring_controller #(
    .RING_TIMEOUT_S (RING),
    .SNOOZE_S       (SNZ),
    .MAX_SNOOZES    (MAXS),
    .TW             (TW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .tick_seg     (tick_seg),
    .alarm_match  (alarm_match),
    .alarm_arm    (alarm_arm),
    .snooze_pulse (snooze_pulse),
    .stop_pulse   (stop_pulse),
    .buzzer       (buzzer),
    .state        (state),
    .snoozes_left (snoozes_left)
  );

  always #5 clock = ~clock;

  task automatic end_event(int next_state);
    m_state = next_state;
    m_buz   = 1'b0;
    m_left  = 0;
    m_timer = 0;
  endtask

  task automatic model_step(bit rst, bit arm, bit match, bit tk, bit snz, bit stp);
    bit rising;
    if (rst) begin
      end_event(S_IDLE);
      m_prev_match = 1'b0;
      return;
    end
    rising       = match && !m_prev_match;
    m_prev_match = match;
    if (!arm) begin
      end_event(S_IDLE);
      return;
    end
    if (m_state == S_IDLE) begin
      m_state = S_ARMED;
    end else if (m_state == S_ARMED) begin
      if (rising) begin
        m_state = S_RINGING;
        m_timer = RING;
        m_left  = MAXS;
        m_buz   = 1'b1;
      end
    end else if (m_state == S_RINGING) begin
      if (stp) end_event(S_ARMED);
      else if (snz && m_left > 0) begin
        m_state = S_SNOOZE;
        m_timer = SNZ;
        m_left  = m_left - 1;
        m_buz   = 1'b0;
      end else if (tk) begin
        if (m_timer == 1) end_event(S_ARMED);
        else begin
          if (m_timer > 0) m_timer = m_timer - 1;
`ifdef ALARM_BEEP_PATTERN_EN
          m_buz = !m_buz;
`endif
        end
      end
    end else begin
      if (stp) end_event(S_ARMED);
      else if (tk) begin
        if (m_timer == 1) begin
          m_state = S_RINGING;
          m_timer = RING;
          m_buz   = 1'b1;
        end else if (m_timer > 0) m_timer = m_timer - 1;
      end
    end
  endtask

  task automatic check_outputs(string tag);
    total++;
    assert (state === 2'(m_state)) else begin
      bad++;
      $error("FAIL %s state got=%0d want=%0d", tag, state, m_state);
    end
    total++;
    assert (buzzer === m_buz) else begin
      bad++;
      $error("FAIL %s buzzer got=%0b want=%0b", tag, buzzer, m_buz);
    end
    total++;
    assert (snoozes_left === 2'(m_left)) else begin
      bad++;
      $error("FAIL %s snoozes_left got=%0d want=%0d", tag, snoozes_left, m_left);
    end
  endtask

  // One clock cycle: drive at the falling edge, check 1 ns after the rising edge.
  task automatic drive(bit rst, bit tk, bit snz, bit stp, string tag);
    @(negedge clock);
    reset        = rst;
    alarm_arm    = cur_arm;
    alarm_match  = cur_match;
    tick_seg     = tk;
    snooze_pulse = snz;
    stop_pulse   = stp;
    @(posedge clock);
    #1;
    model_step(rst, cur_arm, cur_match, tk, snz, stp);
    check_outputs(tag);
  endtask

  task automatic idle_cycle(string tag);
    drive(1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  // Directed check against a literal value derived from the scenario itself.
  task automatic expect_state(string tag, logic [1:0] want_state, logic want_buz);
    total++;
    assert (state === want_state && buzzer === want_buz) else begin
      bad++;
      $error("FAIL %s state/buzzer got=%0d/%0b want=%0d/%0b",
             tag, state, buzzer, want_state, want_buz);
    end
  endtask

  task automatic expect_left(string tag, logic [1:0] want);
    total++;
    assert (snoozes_left === want) else begin
      bad++;
      $error("FAIL %s snoozes_left got=%0d want=%0d", tag, snoozes_left, want);
    end
  endtask

  // Produce a fresh rising edge of alarm_match (low for one cycle, then high).
  task automatic match_edge(string tag);
    cur_match = 1'b0;
    idle_cycle({tag, "_low"});
    cur_match = 1'b1;
    idle_cycle({tag, "_high"});
  endtask

  initial begin
    bit want_buz;

    // Reset.
    drive(1'b1, 1'b0, 1'b0, 1'b0, "reset0");
    drive(1'b1, 1'b0, 1'b0, 1'b0, "reset1");
    expect_state("reset_state", 2'b00, 1'b0);
    expect_left("reset_left", 2'd0);

    // Arm, ring on a match edge, auto-stop after RING ticks.
    cur_arm = 1'b1;
    idle_cycle("arm");
    expect_state("armed", 2'b01, 1'b0);
    cur_match = 1'b1;
    idle_cycle("match_edge");
    expect_state("ringing", 2'b10, 1'b1);
    expect_left("ring_left", 2'd3);
    for (int i = 0; i < RING - 1; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, "ring_tick");
    expect_state("ring_before_timeout", 2'b10, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, "ring_timeout");
    expect_state("auto_stop", 2'b01, 1'b0);

    // Snooze until exhausted; a further snooze is ignored.
    match_edge("snz_edge");
    expect_state("snz_ring", 2'b10, 1'b1);
    for (int k = 0; k < MAXS; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, "snooze");
      expect_state("snoozing", 2'b11, 1'b0);
      expect_left("snooze_left", 2'(MAXS - 1 - k));
      for (int i = 0; i < SNZ - 1; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, "snz_tick");
      expect_state("snz_before_end", 2'b11, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, "snz_end");
      expect_state("snz_resume", 2'b10, 1'b1);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, "snooze_exhausted");
    expect_state("no_more_snooze", 2'b10, 1'b1);
    expect_left("exhausted_left", 2'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, "stop_after_snz");
    expect_state("stopped", 2'b01, 1'b0);

    // Match already high when armed does not ring; stop with match held stays armed.
    cur_arm = 1'b0;
    idle_cycle("disarm");
    expect_state("disarmed", 2'b00, 1'b0);
    cur_match = 1'b1;
    idle_cycle("match_while_idle");
    cur_arm = 1'b1;
    idle_cycle("rearm");
    for (int i = 0; i < 3; i++) idle_cycle("held_match");
    expect_state("no_ring_held_match", 2'b01, 1'b0);
    match_edge("edge2");
    expect_state("ring2", 2'b10, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, "stop_match_high");
    for (int i = 0; i < 3; i++) idle_cycle("post_stop");
    expect_state("stays_armed", 2'b01, 1'b0);

    // Stop beats snooze; arm=0 beats stop.
    match_edge("edge3");
    drive(1'b0, 1'b0, 1'b1, 1'b1, "stop_and_snooze");
    expect_state("stop_wins", 2'b01, 1'b0);
    match_edge("edge4");
    cur_arm = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, "disarm_and_stop");
    expect_state("disarm_wins", 2'b00, 1'b0);

    // Buzzer pattern across ticks while ringing, then silent in snooze.
    cur_arm = 1'b1;
    idle_cycle("arm5");
    match_edge("edge5");
    want_buz = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, "beep_tick");
`ifdef ALARM_BEEP_PATTERN_EN
      want_buz = !want_buz;
`endif
      expect_state("beep", 2'b10, want_buz);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, "beep_snooze");
    expect_state("beep_snooze_quiet", 2'b11, 1'b0);

    // Reset in the middle of ringing.
    drive(1'b0, 1'b0, 1'b0, 1'b1, "stop6");
    match_edge("edge6");
    drive(1'b0, 1'b1, 1'b0, 1'b0, "ring6_tick");
    drive(1'b1, 1'b0, 1'b0, 1'b0, "reset_mid_ring");
    expect_state("reset_mid_ring_state", 2'b00, 1'b0);
    expect_left("reset_mid_ring_left", 2'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      bit rst, tk, snz, stp;
      if ($urandom_range(299) == 0) cur_arm = !cur_arm;
      if ($urandom_range(24) == 0)  cur_match = !cur_match;
      rst = ($urandom_range(399) == 0);
      tk  = ($urandom_range(1) == 0);
      snz = ($urandom_range(15) == 0);
      stp = ($urandom_range(59) == 0);
      drive(rst, tk, snz, stp, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
